// File: rtl/cdr_pkg.sv
// Shared types and defaults for the CDR phase-selection controller.
package cdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_SETTLE = 2'd2
    } cdr_state_e;

    localparam logic DIR_DEC = 1'b0;
    localparam logic DIR_INC = 1'b1;

    localparam int CDR_NUM_PHASES = 8;
    localparam int CDR_VOTE_WIN   = 16;

    // Per-sample verdict from the vote accumulator.
    typedef struct packed {
        logic close;
        logic inc;
        logic dec;
    } vote_t;

endpackage

// File: rtl/cdr_phase_controller_if.sv
// Detector-side samples in, phase-mux selection and status out.
interface cdr_phase_controller_if #(
    parameter int PHASE_W = 3
);
    logic               en;
    logic               up;
    logic               down;
    logic [PHASE_W-1:0] phase_sel;
    logic               step_valid;
    logic               step_dir;
    logic               locked;
    logic [1:0]         state;

    modport master (
        output en, up, down,
        input  phase_sel, step_valid, step_dir, locked, state
    );

    modport slave (
        input  en, up, down,
        output phase_sel, step_valid, step_dir, locked, state
    );
endinterface

// File: rtl/cdr_phase_controller_vote_accumulator.sv
// Majority vote of up/down samples over fixed windows; flags the closing sample
// and whether the window's net vote crosses the step threshold.
module vote_accumulator
    import cdr_pkg::*;
#(
    parameter int VOTE_WIN = CDR_VOTE_WIN,
    parameter int THRESH   = 4
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  sample_en,
    input  logic  up,
    input  logic  down,
    output vote_t vote
);
    localparam int WIN_W = $clog2(VOTE_WIN);
    localparam int NET_W = $clog2(VOTE_WIN) + 2;
    localparam logic signed [NET_W-1:0] THR_P = NET_W'(THRESH);
    localparam logic signed [NET_W-1:0] THR_N = -THR_P;

    logic [WIN_W-1:0]        win_q;
    logic signed [NET_W-1:0] net_q, net_d, contrib;

    always_comb begin
        contrib = '0;
        if (up && !down)      contrib = NET_W'(1);
        else if (down && !up) contrib = -NET_W'(1);
        net_d      = net_q + contrib;
        vote.close = sample_en && (win_q == WIN_W'(VOTE_WIN - 1));
        vote.inc   = vote.close && (net_d >= THR_P);
        vote.dec   = vote.close && (net_d <= THR_N);
    end

    always_ff @(posedge clk) begin
        if (rst || !sample_en || vote.close) begin
            win_q <= '0;
            net_q <= '0;
        end else begin
            win_q <= win_q + 1'b1;
            net_q <= net_d;
        end
    end
endmodule

// File: rtl/cdr_phase_controller.sv
// Phase-selection FSM: steps the clock-mux index on window votes, blanks the
// detector while the mux settles, and tracks lock from step history.
module cdr_phase_controller
    import cdr_pkg::*;
#(
    parameter int NUM_PHASES   = CDR_NUM_PHASES,
    parameter int PHASE_W      = $clog2(NUM_PHASES),
    parameter int VOTE_WIN     = CDR_VOTE_WIN,
    parameter int THRESH       = 4,
    parameter int SETTLE       = 4,
    parameter int LOCK_WINDOWS = 8,
    parameter int UNLOCK_STEPS = 3
) (
    input logic                   clk,
    input logic                   rst,
    cdr_phase_controller_if.slave cdr
);
    localparam int SETTLE_W = $clog2(SETTLE + 1);
    localparam int QUIET_W  = $clog2(LOCK_WINDOWS + 1);
    localparam int SAME_W   = $clog2(UNLOCK_STEPS + 1);

    cdr_state_e          state_q;
    logic [PHASE_W-1:0]  phase_q;
    logic                step_valid_q, step_dir_q, locked_q;
    logic [SETTLE_W-1:0] settle_q;
    logic [QUIET_W-1:0]  quiet_q, quiet_d;
    logic [SAME_W-1:0]   same_q, same_d;
    vote_t               vote;

    vote_accumulator #(.VOTE_WIN(VOTE_WIN), .THRESH(THRESH)) u_vote (
        .clk       (clk),
        .rst       (rst),
        .sample_en (cdr.en && (state_q == ST_TRACK)),
        .up        (cdr.up),
        .down      (cdr.down),
        .vote      (vote)
    );

    // Both counters saturate; same_d is only consumed on a step, where vote.inc gives the direction.
    always_comb begin
        quiet_d = (quiet_q == QUIET_W'(LOCK_WINDOWS)) ? quiet_q : quiet_q + 1'b1;
        if (vote.inc != step_dir_q)                 same_d = SAME_W'(1);
        else if (same_q == SAME_W'(UNLOCK_STEPS))   same_d = same_q;
        else                                        same_d = same_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= '0;
            step_valid_q <= 1'b0;
            step_dir_q   <= DIR_DEC;
            locked_q     <= 1'b0;
            settle_q     <= '0;
            quiet_q      <= '0;
            same_q       <= '0;
        end else begin
            step_valid_q <= 1'b0;
            if (!cdr.en) begin
                state_q  <= ST_IDLE;
                settle_q <= '0;
                quiet_q  <= '0;
                locked_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: state_q <= ST_TRACK;
                    ST_TRACK: begin
                        if (vote.inc || vote.dec) begin
                            phase_q      <= vote.inc ? phase_q + 1'b1 : phase_q - 1'b1;
                            step_dir_q   <= vote.inc ? DIR_INC : DIR_DEC;
                            step_valid_q <= 1'b1;
                            state_q      <= ST_SETTLE;
                            settle_q     <= SETTLE_W'(SETTLE);
                            quiet_q      <= '0;
                            same_q       <= same_d;
                            if (same_d >= SAME_W'(UNLOCK_STEPS)) locked_q <= 1'b0;
                        end else if (vote.close) begin
                            quiet_q <= quiet_d;
                            if (quiet_d == QUIET_W'(LOCK_WINDOWS)) locked_q <= 1'b1;
                        end
                    end
                    ST_SETTLE: begin
                        if (settle_q <= SETTLE_W'(1)) begin
                            state_q  <= ST_TRACK;
                            settle_q <= '0;
                        end else begin
                            settle_q <= settle_q - 1'b1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign cdr.phase_sel  = phase_q;
    assign cdr.step_valid = step_valid_q;
    assign cdr.step_dir   = step_dir_q;
    assign cdr.locked     = locked_q;
    assign cdr.state      = state_q;
endmodule

// File: tb/tb_cdr_phase_controller.sv
// Directed bench for cdr_phase_controller with default parameters.
module tb_cdr_phase_controller;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    cdr_phase_controller_if #(.PHASE_W(3)) bus ();

    cdr_phase_controller dut (
        .clk (clk),
        .rst (rst),
        .cdr (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic u, input logic d);
        bus.up   = u;
        bus.down = d;
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        drive(0, 0);
        tick(2);
        rst = 1'b0;
        check("rst_phase", 32'(bus.phase_sel), 0);
        check("rst_valid", 32'(bus.step_valid), 0);
        check("rst_dir", 32'(bus.step_dir), 0);
        check("rst_locked", 32'(bus.locked), 0);
        check("rst_state", 32'(bus.state), 0);

        // Constant up from phase 0
        bus.en = 1'b1;
        drive(1, 0);
        tick(1);
        check("idle_to_track", 32'(bus.state), 1);
        tick(15);
        check("up_before16", 32'(bus.phase_sel), 0);
        tick(1);
        check("up_step_phase", 32'(bus.phase_sel), 1);
        check("up_step_valid", 32'(bus.step_valid), 1);
        check("up_step_dir", 32'(bus.step_dir), 1);
        check("up_step_state", 32'(bus.state), 2);
        tick(1);
        check("valid_one_cycle", 32'(bus.step_valid), 0);
        tick(2);
        check("settle_3rd", 32'(bus.state), 2);
        tick(1);
        check("settle_done", 32'(bus.state), 1);
        tick(16);
        check("up_step2", 32'(bus.phase_sel), 2);
        for (int s = 3; s <= 8; s++) begin
            tick(20);
            check("up_periodic", 32'(bus.phase_sel), 32'(s % 8));
        end
        check("wrap_valid", 32'(bus.step_valid), 1);

        // Constant down from phase 0
        drive(0, 1);
        tick(20);
        check("down_phase", 32'(bus.phase_sel), 7);
        check("down_dir", 32'(bus.step_dir), 0);
        check("down_valid", 32'(bus.step_valid), 1);

        // Threshold boundaries
        drive(0, 0);
        tick(4);
        check("thr_track", 32'(bus.state), 1);
        for (int i = 0; i < 16; i++) begin
            drive(i < 10, i >= 10);
            tick(1);
        end
        check("net4_phase", 32'(bus.phase_sel), 0);
        check("net4_dir", 32'(bus.step_dir), 1);
        tick(4);
        for (int i = 0; i < 16; i++) begin
            drive(i < 9, i >= 9);
            tick(1);
        end
        check("net2_phase", 32'(bus.phase_sel), 0);
        check("net2_state", 32'(bus.state), 1);
        check("net2_valid", 32'(bus.step_valid), 0);
        drive(1, 1);
        tick(16);
        check("net0_phase", 32'(bus.phase_sel), 0);
        drive(1, 0);
        tick(15);
        check("close16_pre", 32'(bus.phase_sel), 0);
        tick(1);
        check("close16_step", 32'(bus.phase_sel), 1);

        // Reset mid-SETTLE
        tick(1);
        check("mid_settle", 32'(bus.state), 2);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        check("rst2_phase", 32'(bus.phase_sel), 0);
        check("rst2_locked", 32'(bus.locked), 0);
        check("rst2_valid", 32'(bus.step_valid), 0);
        check("rst2_state", 32'(bus.state), 0);
        tick(1);
        check("rst2_track", 32'(bus.state), 1);

        // Alternating votes lock after 8 quiet windows
        for (int w = 0; w < 8; w++) begin
            if (w == 7) check("lock_pre", 32'(bus.locked), 0);
            for (int i = 0; i < 16; i++) begin
                drive(i < 8, i >= 8);
                tick(1);
            end
        end
        check("lock_set", 32'(bus.locked), 1);
        check("lock_phase", 32'(bus.phase_sel), 0);

        // Two up steps, one down: dithering keeps lock
        drive(1, 0);
        tick(16);
        check("dith_up1", 32'(bus.phase_sel), 1);
        tick(20);
        check("dith_up2", 32'(bus.phase_sel), 2);
        check("dith_lock2", 32'(bus.locked), 1);
        drive(0, 1);
        tick(20);
        check("dith_down", 32'(bus.phase_sel), 1);
        check("dith_lock3", 32'(bus.locked), 1);

        // Three consecutive up steps drop lock on the third
        drive(1, 0);
        tick(20);
        check("run_up1_lock", 32'(bus.locked), 1);
        tick(20);
        check("run_up2_lock", 32'(bus.locked), 1);
        tick(20);
        check("run_up3_phase", 32'(bus.phase_sel), 4);
        check("run_up3_lock", 32'(bus.locked), 0);

        // en dropped mid-window restarts the window
        tick(4);
        tick(10);
        bus.en = 1'b0;
        tick(1);
        check("en_off_state", 32'(bus.state), 0);
        check("en_off_phase", 32'(bus.phase_sel), 4);
        bus.en = 1'b1;
        tick(1);
        check("en_on_state", 32'(bus.state), 1);
        tick(6);
        check("restart_phase", 32'(bus.phase_sel), 4);
        check("restart_valid", 32'(bus.step_valid), 0);
        tick(10);
        check("restart_close", 32'(bus.phase_sel), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cdr_phase_controller.md
Name: cdr_phase_controller

Overview:
- Phase-selection controller for the oversampled CDR. It consumes the bang-bang phase detector's up/down outputs, majority-votes them over fixed windows and steps a registered phase index into the multiphase clock mux.
- It also blanks detector output while the mux settles and reports lock.
- It sits between the phase detector and the clock-phase mux, all in the recovered-clock domain `clk`.

Parameters:
- NUM_PHASES, 8: number of selectable clock phases; power of two, ≥4.
- PHASE_W, $clog2(NUM_PHASES): phase index width.
- VOTE_WIN, 16: detector samples per voting window; ≥2.
- THRESH, 4: minimum |net votes| in one window that triggers a step; 1..VOTE_WIN.
- SETTLE, 4: cycles for which inputs are ignored after a step; ≥1.
- LOCK_WINDOWS, 8: consecutive step-free windows before `locked` asserts.
- UNLOCK_STEPS, 3: consecutive same-direction steps that clear `locked`.

Ports:
- clk, input, 1: recovered/system clock; all logic is rising-edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: tracking enable.
- up, input, 1: phase detector up (early≠edge).
- down, input, 1: phase detector down (late≠edge).
- phase_sel, output, PHASE_W: registered phase index to the clock mux.
- step_valid, output, 1: one-cycle pulse in the cycle after phase_sel changes.
- step_dir, output, 1: direction of the last step; 1=increment, 0=decrement. Held between steps.
- locked, output, 1: lock indicator.
- state, output, 2: FSM state, for debug.

Behaviour:
- Reset (rst=1 at a clk edge; it overrides everything, including mid-window and mid-SETTLE):
  - phase_sel=0, step_valid=0, step_dir=0, locked=0, state=IDLE.
  - Window count, net count, settle count, quiet count and same-direction count all =0.
- FSM states are IDLE=0, TRACK=1, SETTLE=2. Encoding 3 is unused and returns to IDLE.
- IDLE:
  - Counters are held at 0 and phase_sel is held.
  - en=1 → TRACK at the next edge.
- en=0 in any state → IDLE at the next edge.
  - Window, net, settle and quiet counts clear; locked clears.
  - phase_sel is retained.
- TRACK: one sample is consumed per cycle.
  - Net count is signed, width $clog2(VOTE_WIN)+2. up&~down adds +1; down&~up adds −1; both or neither adds 0.
  - Every cycle increments the window count, including neutral samples.
- Window close: on the edge that consumes sample VOTE_WIN, compute net' = net plus this sample's contribution.
  - net' ≥ THRESH → phase_sel ← (phase_sel+1) mod NUM_PHASES, step_dir ← 1.
  - net' ≤ −THRESH → phase_sel ← (phase_sel−1) mod NUM_PHASES, step_dir ← 0.
  - In either step case: state → SETTLE, settle count loaded with SETTLE, and step_valid=1 during the following cycle only.
  - Otherwise there is no step, state stays TRACK, and quiet count increments, saturating at LOCK_WINDOWS.
  - Window and net counts clear at every close.
- Wrap-around: 7 +1 → 0 and 0 −1 → 7 (modular, no saturation).
- SETTLE:
  - up/down are ignored and the counters do not advance.
  - After exactly SETTLE cycles in SETTLE → TRACK. The first sample is taken in the next cycle.
  - Step period under constant up is VOTE_WIN+SETTLE = 20 cycles.
- Lock:
  - locked sets at the edge where quiet count reaches LOCK_WINDOWS.
  - Any step clears quiet count.
  - A step in the same direction as the previous step increments the same-direction count; an opposite-direction step sets it to 1.
  - locked clears when the same-direction count reaches UNLOCK_STEPS. Alternating-direction dithering keeps locked=1.
- Latency: phase_sel changes at the edge consuming the deciding sample; step_valid is high the following cycle.

Decomposition:
- Package cdr_pkg:
  - State enum (IDLE/TRACK/SETTLE).
  - Step direction constants DIR_DEC=0 and DIR_INC=1.
  - Shared default constants for NUM_PHASES and VOTE_WIN, reused by the phase mux.
- Sub-module vote_accumulator: window counter, signed net counter and the window-close/threshold compare outputs (close, inc, dec).
- The FSM, phase register and lock logic stay in the top level.

Test Plan:
- Reset: rst=1 for 2 cycles mid-SETTLE → next cycle phase_sel=0, locked=0, step_valid=0, state=0; en=1 then gives TRACK after 1 cycle.
- Constant up=1, down=0 from phase 0:
  - phase_sel=1 after the 16th sample, with step_valid pulsed for 1 cycle and step_dir=1.
  - The next 4 cycles are ignored.
  - 8 steps (160 cycles) wrap phase_sel back to 0.
- Constant down=1 from phase 0 → phase_sel=7 after 16 samples, step_dir=0.
- Threshold boundaries within one window:
  - 10 up + 6 down (net +4) → step.
  - 9 up + 7 down (net +2) → no step.
  - 16 cycles with up=down=1 (net 0) → no step; window still closes at 16.
- Alternating up/down for 8 windows → no steps, locked=1 at the 8th window close.
  - Then 2 up steps followed by 1 down step → locked stays 1.
  - Then 3 consecutive up steps → locked=0 at the 3rd.
- en dropped mid-window after 10 up samples → IDLE, phase_sel unchanged.
  - Re-enable then 6 up samples → no step; the window restarts from 0.
